// File: rtl/pet_pkg.sv
// Shared PET definitions: loader FSM encoding and RAM / zero-page constants.
package pet_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_LO = 3'd1,
    S_HDR_HI = 3'd2,
    S_DATA   = 3'd3,
    S_FIX    = 3'd4
  } prg_state_t;

  // Highest byte of the 32KB main RAM.
  localparam logic [14:0] PET_RAM_TOP = 15'h7FFF;
  // VARTAB lo; ARYTAB and STREND pointer pairs follow directly.
  localparam logic [14:0] PET_VARTAB  = 15'h002A;

endpackage

// File: rtl/pet_prg_loader.sv
// PRG download stream -> PET RAM DMA writes.
// Optional macro PRG_PTR_FIXUP_EN: after the payload, patch VARTAB/ARYTAB/STREND
// with the end-of-program address so the program can be RUN straight away.
module pet_prg_loader
  import pet_pkg::*;
#(
  parameter logic [14:0] RAM_TOP  = PET_RAM_TOP,
  parameter logic [14:0] PTR_BASE = PET_VARTAB
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic [14:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        overflow,
  output logic        short_file
);

  localparam logic [15:0] TOP16 = {1'b0, RAM_TOP};

  prg_state_t  state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic        act_q, act_d;
  logic        pend_q, pend_d;
  logic [14:0] dma_addr_q, dma_addr_d;
  logic [7:0]  dma_din_q, dma_din_d;
  logic        dma_we_q, dma_we_d;
  logic        ovf_q, ovf_d;
  logic        short_q, short_d;
`ifdef PRG_PTR_FIXUP_EN
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] end_ptr;

  // Program end as BASIC sees it: clamp to one past the top of RAM.
  assign end_ptr = (ptr_q > TOP16) ? (TOP16 + 16'd1) : ptr_q;
`endif

  assign dl_wait    = (state_q == S_FIX);
  assign busy       = (state_q != S_IDLE);
  assign dma_addr   = dma_addr_q;
  assign dma_din    = dma_din_q;
  assign dma_we     = dma_we_q;
  assign overflow   = ovf_q;
  assign short_file = short_q;

  // Next-state, pointer and DMA stage logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    act_d      = dl_active;
    pend_d     = pend_q;
    dma_addr_d = dma_addr_q;
    dma_din_d  = dma_din_q;
    dma_we_d   = 1'b0;
    ovf_d      = ovf_q;
    short_d    = short_q;
`ifdef PRG_PTR_FIXUP_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // A rise latched during FIX counts as a start even if the line dropped again.
        if (dl_active || pend_q) begin
          pend_d  = 1'b0;
          ovf_d   = 1'b0;
          short_d = 1'b0;
          // A byte released the moment dl_wait drops lands here; keep it as header lo.
          if (dl_wr) begin
            ptr_d[7:0] = dl_data;
            state_d    = S_HDR_HI;
          end else begin
            state_d    = S_HDR_LO;
          end
        end
      end
      S_HDR_LO: begin
        if (!dl_active) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end else if (dl_wr) begin
          ptr_d[7:0] = dl_data;
          state_d    = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (dl_wr) begin
          ptr_d[15:8] = dl_data;
          // Header-only file ending on this byte still gets its pointer fixup.
          state_d     = dl_active ? S_DATA : S_FIX;
        end else if (!dl_active) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (dl_wr) begin
          if (ptr_q > TOP16) begin
            ovf_d = 1'b1;
          end else begin
            dma_we_d   = 1'b1;
            dma_addr_d = ptr_q[14:0];
            dma_din_d  = dl_data;
          end
          // Saturate so a runaway file can never wrap back into low RAM.
          ptr_d = (ptr_q == 16'hFFFF) ? ptr_q : ptr_q + 16'd1;
        end
        if (!dl_active) state_d = S_FIX;
      end
      S_FIX: begin
        if (dl_active && !act_q) pend_d = 1'b1;
`ifdef PRG_PTR_FIXUP_EN
        dma_we_d   = 1'b1;
        dma_addr_d = PTR_BASE + {12'd0, cnt_q};
        dma_din_d  = cnt_q[0] ? end_ptr[15:8] : end_ptr[7:0];
        if (cnt_q == 3'd5) begin
          cnt_d   = 3'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 3'd1;
        end
`else
        // Address parks on the pointer block; no strobe is issued.
        dma_addr_d = PTR_BASE;
        state_d    = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered DMA output stage; reset aborts any transfer at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 16'd0;
      act_q      <= 1'b0;
      pend_q     <= 1'b0;
      dma_addr_q <= 15'd0;
      dma_din_q  <= 8'd0;
      dma_we_q   <= 1'b0;
      ovf_q      <= 1'b0;
      short_q    <= 1'b0;
`ifdef PRG_PTR_FIXUP_EN
      cnt_q      <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      dma_addr_q <= dma_addr_d;
      dma_din_q  <= dma_din_d;
      dma_we_q   <= dma_we_d;
      ovf_q      <= ovf_d;
      short_q    <= short_d;
`ifdef PRG_PTR_FIXUP_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule
